// File: rtl/timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : timer_pkg                                              |
// | Description : Shared constants for the prescaled timer: mode         |
// |               encodings and default prescaler/counter widths.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package timer_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int PRE_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : timer_prescaler                                        |
// | Description : Programmable prescaler. Counts 0..prescale while       |
// |               enabled and raises tick on the terminal state, which   |
// |               the main counter uses as its clock enable.             |
// | Ports       : clk, rst    - clock, async active-high reset           |
// |               clr         - synchronous clear to 0 (timer start)     |
// |               run_en      - advance enable (running & en)            |
// |               prescale    - terminal value, ratio = prescale+1       |
// |               pre_count   - prescaler state                          |
// |               tick        - terminal enable, combinational           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module timer_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run_en,
  input  logic [PRE_W-1:0] prescale,
  output logic [PRE_W-1:0] pre_count,
  output logic             tick
);

  // >= rather than == so that lowering prescale below the current state
  // terminates immediately instead of wrapping through the full range.
  assign tick = run_en & (pre_count >= prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_count <= '0;
    end else if (clr) begin
      pre_count <= '0;
    end else if (run_en) begin
      pre_count <= tick ? '0 : pre_count + 1'b1;
    end
  end

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/prescaled_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : prescaled_timer                                        |
// | Description : Prescaled up-counter with reload, compare strobe,      |
// |               periodic/one-shot mode and sticky overflow flag.       |
// |               Single clock domain; the prescaler yields a tick       |
// |               enable rather than a derived clock.                    |
// | Ports       : clk, rst    - clock, async active-high reset           |
// |               en          - global count enable                      |
// |               mode        - 0 periodic, 1 one-shot                   |
// |               prescale    - prescaler terminal value                 |
// |               reload      - value loaded on start / overflow         |
// |               compare     - compare value for cmp_match              |
// |               start/stop  - run control pulses (start wins)          |
// |               ovf_clr     - clear pulse for ovf_flag                 |
// |               pre_count, count - prescaler / counter state           |
// |               tick        - prescaler terminal enable                |
// |               ovf_pulse, cmp_match - registered one-cycle strobes    |
// |               ovf_flag    - sticky overflow; running - timer active  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module prescaled_timer
  import timer_pkg::*;
#(
  parameter int PRE_W = PRE_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] reload,
  input  logic [CNT_W-1:0] compare,
  input  logic             start,
  input  logic             stop,
  input  logic             ovf_clr,
  output logic [PRE_W-1:0] pre_count,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             ovf_pulse,
  output logic             ovf_flag,
  output logic             cmp_match,
  output logic             running
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             wrap;
  logic             advance;
  logic [CNT_W-1:0] next_count;

  timer_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .run_en    (running & en),
    .prescale  (prescale),
    .pre_count (pre_count),
    .tick      (tick)
  );

  assign wrap       = (count == CNT_MAX);
  assign next_count = wrap ? reload : count + 1'b1;

  // A tick only advances the counter when neither control pulse is
  // present; start/stop take precedence and suppress the strobes.
  assign advance = tick & ~start & ~stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      ovf_pulse <= 1'b0;
      ovf_flag  <= 1'b0;
      cmp_match <= 1'b0;
      running   <= 1'b0;
    end else begin
      ovf_pulse <= advance & wrap;
      cmp_match <= advance & (next_count == compare);

      // Setting beats clearing when both land on the same edge.
      if (advance & wrap) begin
        ovf_flag <= 1'b1;
      end else if (ovf_clr) begin
        ovf_flag <= 1'b0;
      end

      if (start) begin
        count   <= reload;
        running <= 1'b1;
      end else if (stop) begin
        running <= 1'b0;
      end else if (advance) begin
        count <= next_count;
        if (wrap && (mode == MODE_ONESHOT)) begin
          running <= 1'b0;
        end
      end
    end
  end

endmodule : prescaled_timer
`default_nettype wire

// File: tb/tb_prescaled_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_prescaled_timer                                     |
// | Description : Self-checking bench for prescaled_timer. Expected      |
// |               strobe times come from the start/latency relationship  |
// |               and are queued when a scenario is launched; a monitor  |
// |               pops them as the DUT strobes.                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_prescaled_timer;
  import timer_pkg::*;

  localparam int PRE_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             mode = MODE_PERIODIC;
  logic [PRE_W-1:0] prescale = '0;
  logic [CNT_W-1:0] reload = '0;
  logic [CNT_W-1:0] compare = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             ovf_clr = 1'b0;
  logic [PRE_W-1:0] pre_count;
  logic [CNT_W-1:0] count;
  logic             tick;
  logic             ovf_pulse;
  logic             ovf_flag;
  logic             cmp_match;
  logic             running;

  prescaled_timer #(
    .PRE_W (PRE_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .prescale  (prescale),
    .reload    (reload),
    .compare   (compare),
    .start     (start),
    .stop      (stop),
    .ovf_clr   (ovf_clr),
    .pre_count (pre_count),
    .count     (count),
    .tick      (tick),
    .ovf_pulse (ovf_pulse),
    .ovf_flag  (ovf_flag),
    .cmp_match (cmp_match),
    .running   (running)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at_cyc;
    int unsigned val;
  } exp_t;

  exp_t ovf_q[$];
  exp_t cmp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ovf(input int unsigned at, input int unsigned val);
    exp_t e;
    e.at_cyc = at;
    e.val    = val;
    ovf_q.push_back(e);
  endtask

  task automatic push_cmp(input int unsigned at, input int unsigned val);
    exp_t e;
    e.at_cyc = at;
    e.val    = val;
    cmp_q.push_back(e);
  endtask

  // Strobe monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ovf_pulse !== 1'b0) begin
      if (ovf_q.size() == 0) begin
        check_val("ovf_spurious", {31'b0, ovf_pulse}, 32'd0);
      end else begin
        e = ovf_q.pop_front();
        check_val("ovf_cycle", cyc, e.at_cyc);
        check_val("ovf_count", {24'b0, count}, e.val);
      end
    end
    if (cmp_match !== 1'b0) begin
      if (cmp_q.size() == 0) begin
        check_val("cmp_spurious", {31'b0, cmp_match}, 32'd0);
      end else begin
        e = cmp_q.pop_front();
        check_val("cmp_cycle", cyc, e.at_cyc);
        check_val("cmp_count", {24'b0, count}, e.val);
      end
    end
  end

  // Advance to 2 time units after rising edge n.
  task automatic step_to(input int unsigned n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Advance into the low phase of the cycle that follows edge n.
  task automatic sample_at(input int unsigned n);
    step_to(n);
    @(negedge clk);
  endtask

  // Called 2 units after an edge; start is sampled on the next edge (E0).
  task automatic do_start(output int unsigned e0);
    start = 1'b1;
    e0    = cyc + 1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(posedge clk);
    #2;
    stop = 1'b0;
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    @(posedge clk);
    #2;
    ovf_clr = 1'b0;
  endtask

  task automatic check_queues_empty(input string tag);
    check_val({tag, "_ovf_left"}, ovf_q.size(), 32'd0);
    check_val({tag, "_cmp_left"}, cmp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  int unsigned e0;

  initial begin
    // Reset state
    @(negedge clk);
    check_val("rst_count", {24'b0, count}, 32'd0);
    check_val("rst_pre", {28'b0, pre_count}, 32'd0);
    check_val("rst_running", {31'b0, running}, 32'd0);
    check_val("rst_flag", {31'b0, ovf_flag}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    en  = 1'b1;

    // 1: prescale 0, reload 0, periodic
    prescale = 4'd0; reload = 8'h00; compare = 8'h10; mode = MODE_PERIODIC;
    do_start(e0);
    push_cmp(e0 + 16, 32'h10);
    push_ovf(e0 + 256, 32'h00);
    sample_at(e0 + 8);
    check_val("s1_count8", {24'b0, count}, 32'd8);
    check_val("s1_tick", {31'b0, tick}, 32'd1);
    sample_at(e0 + 260);
    check_val("s1_count_wrapped", {24'b0, count}, 32'd4);
    check_val("s1_running", {31'b0, running}, 32'd1);
    check_val("s1_flag", {31'b0, ovf_flag}, 32'd1);
    step_to(e0 + 261);
    pulse_stop();
    sample_at(e0 + 270);
    check_val("s1_stop_count", {24'b0, count}, 32'd5);
    check_val("s1_stop_running", {31'b0, running}, 32'd0);
    check_val("s1_stop_tick", {31'b0, tick}, 32'd0);
    step_to(e0 + 271);
    pulse_clr();
    sample_at(e0 + 273);
    check_val("s1_flag_clr", {31'b0, ovf_flag}, 32'd0);
    check_queues_empty("s1");

    // 2: prescale 15 -> overflow every 4096 cycles
    step_to(cyc + 1);
    prescale = 4'd15; reload = 8'h00; compare = 8'h80;
    do_start(e0);
    push_cmp(e0 + 2048, 32'h80);
    push_ovf(e0 + 4096, 32'h00);
    push_cmp(e0 + 6144, 32'h80);
    push_ovf(e0 + 8192, 32'h00);
    sample_at(e0 + 4100);
    check_val("s2_flag_set", {31'b0, ovf_flag}, 32'd1);
    step_to(e0 + 4101);
    pulse_clr();
    sample_at(e0 + 4103);
    check_val("s2_flag_clr", {31'b0, ovf_flag}, 32'd0);
    sample_at(e0 + 8000);
    check_val("s2_flag_still_clr", {31'b0, ovf_flag}, 32'd0);
    sample_at(e0 + 8195);
    check_val("s2_flag_set2", {31'b0, ovf_flag}, 32'd1);
    check_val("s2_count", {24'b0, count}, 32'd0);
    step_to(e0 + 8196);
    pulse_stop();
    pulse_clr();
    check_queues_empty("s2");

    // 3: one-shot, prescale 1, reload 250
    prescale = 4'd1; reload = 8'd250; compare = 8'd250; mode = MODE_ONESHOT;
    do_start(e0);
    push_ovf(e0 + 12, 32'd250);
    push_cmp(e0 + 12, 32'd250);
    sample_at(e0 + 4);
    check_val("s3_count", {24'b0, count}, 32'd252);
    sample_at(e0 + 112);
    check_val("s3_running", {31'b0, running}, 32'd0);
    check_val("s3_hold", {24'b0, count}, 32'd250);
    check_val("s3_pre", {28'b0, pre_count}, 32'd0);
    check_val("s3_flag", {31'b0, ovf_flag}, 32'd1);
    check_queues_empty("s3");
    step_to(cyc + 1);
    pulse_clr();

    // 4: compare 0x80 from reload 0x7E, then en low for 10 edges
    prescale = 4'd0; reload = 8'h7E; compare = 8'h80; mode = MODE_PERIODIC;
    do_start(e0);
    push_cmp(e0 + 2, 32'h80);
    step_to(e0 + 5);
    en = 1'b0;
    for (int k = 6; k <= 14; k++) begin
      sample_at(e0 + k);
      check_val("s4_frozen_count", {24'b0, count}, 32'h83);
      check_val("s4_frozen_tick", {31'b0, tick}, 32'd0);
    end
    check_val("s4_frozen_pre", {28'b0, pre_count}, 32'd0);
    step_to(e0 + 15);
    en = 1'b1;
    sample_at(e0 + 15);
    check_val("s4_last_frozen", {24'b0, count}, 32'h83);
    sample_at(e0 + 16);
    check_val("s4_resumed", {24'b0, count}, 32'h84);
    step_to(e0 + 17);
    pulse_stop();
    check_queues_empty("s4");

    // 5a: overflow edge coinciding with ovf_clr
    prescale = 4'd0; reload = 8'hFC; compare = 8'h00;
    do_start(e0);
    push_ovf(e0 + 4, 32'hFC);
    step_to(e0 + 3);
    ovf_clr = 1'b1;
    step_to(e0 + 4);
    ovf_clr = 1'b0;
    sample_at(e0 + 4);
    check_val("s5_set_beats_clr", {31'b0, ovf_flag}, 32'd1);
    step_to(e0 + 5);
    pulse_stop();
    check_queues_empty("s5a");

    // 5b: start and stop together, then prescale lowered mid-count
    prescale = 4'd15; reload = 8'h10;
    stop = 1'b1;
    do_start(e0);
    stop = 1'b0;
    sample_at(e0);
    check_val("s5_startstop_run", {31'b0, running}, 32'd1);
    check_val("s5_startstop_count", {24'b0, count}, 32'h10);
    step_to(e0 + 9);
    check_val("s5_pre9", {28'b0, pre_count}, 32'd9);
    check_val("s5_no_tick", {31'b0, tick}, 32'd0);
    prescale = 4'd2;
    sample_at(e0 + 9);
    check_val("s5_tick_now", {31'b0, tick}, 32'd1);
    sample_at(e0 + 10);
    check_val("s5_pre_wrapped", {28'b0, pre_count}, 32'd0);
    check_val("s5_count_adv", {24'b0, count}, 32'h11);
    step_to(e0 + 11);
    pulse_stop();
    check_queues_empty("s5b");

    // 6: asynchronous reset mid-count
    prescale = 4'd0; reload = 8'h50; compare = 8'h00;
    do_start(e0);
    step_to(e0 + 5);
    check_val("s6_pre_rst_count", {24'b0, count}, 32'h55);
    check_val("s6_pre_rst_flag", {31'b0, ovf_flag}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_val("s6_async_count", {24'b0, count}, 32'd0);
    check_val("s6_async_pre", {28'b0, pre_count}, 32'd0);
    check_val("s6_async_flag", {31'b0, ovf_flag}, 32'd0);
    check_val("s6_async_running", {31'b0, running}, 32'd0);
    check_val("s6_async_strobes", {29'b0, ovf_pulse, cmp_match, tick}, 32'd0);
    step_to(e0 + 7);
    rst = 1'b0;
    sample_at(e0 + 27);
    check_val("s6_idle_count", {24'b0, count}, 32'd0);
    check_val("s6_idle_running", {31'b0, running}, 32'd0);
    check_val("s6_idle_pre", {28'b0, pre_count}, 32'd0);
    check_queues_empty("s6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_prescaled_timer
`default_nettype wire
